bin_weight_mac_seq: RTL and testbench
=====================================

BIN_WEIGHT_MAC_SEQ -- requirements
Module: bin_weight_mac_seq

Interface
REQ-001 SHALL have parameter IN_DIM, default 8: input vector length.
REQ-002 SHALL have parameter OUT_DIM, default 4: number of output neurons.
REQ-003 SHALL have parameter BIT_CNT, default 8: two's-complement width of each input and output value.
REQ-004 SHALL have parameter LANES, default 2: input values consumed per accepted beat.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1: reset; synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1: input beat valid.
REQ-008 SHALL have port in_ready, output, 1: block accepts a beat.
REQ-009 SHALL have port in_data, input, LANES*BIT_CNT: lane k at [k*BIT_CNT +: BIT_CNT], signed.
REQ-010 SHALL have port in_weight, input, OUT_DIM*LANES: bit [o*LANES+k] is the weight for neuron o, lane k; 1 = +1, 0 = -1.
REQ-011 SHALL have port out_valid, output, 1: result vector valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port out_data, output, OUT_DIM*BIT_CNT: neuron o at [o*BIT_CNT +: BIT_CNT], saturated signed.
REQ-014 SHALL have port out_sign, output, OUT_DIM: bit o = 1 iff accumulator o >= 0 (binarised activation).
REQ-015 SHALL have port out_sat, output, OUT_DIM: bit o = 1 iff out_data for neuron o was clamped.

Function
REQ-016 SHALL fail elaboration unless IN_DIM % LANES == 0; BEATS = IN_DIM/LANES.
REQ-017 SHALL keep OUT_DIM signed accumulators of ACC_BIT = BIT_CNT + clog2(IN_DIM) + 1 bits; no accumulator overflow is possible.
REQ-018 SHALL, per accepted beat (in_valid && in_ready), add to accumulator o, for each lane k, the sign-extended lane value if the weight bit is 1, else its two's-complement negation computed at ACC_BIT width (so -2^(BIT_CNT-1) negates exactly).
REQ-019 SHALL implement states IDLE (beat count 0, accumulators 0), ACC (beat count 1..BEATS-1), DONE.
REQ-020 SHALL assert in_ready in IDLE and ACC; SHALL deassert in_ready in DONE.
REQ-021 SHALL transition IDLE->ACC on the first accepted beat, or IDLE->DONE directly when BEATS == 1.
REQ-022 SHALL transition ACC->DONE on acceptance of beat number BEATS; ACC is held with no change while in_valid is low.
REQ-023 SHALL assert out_valid exactly in DONE, starting the cycle after the final beat is accepted (latency 1).
REQ-024 SHALL drive out_data[o] = clamp(acc[o], -2^(BIT_CNT-1), 2^(BIT_CNT-1)-1), registered, with out_sat/out_sign derived from the same value.
REQ-025 SHALL hold out_data, out_sign and out_sat stable while out_valid && !out_ready.
REQ-026 SHALL, on out_valid && out_ready, transition DONE->IDLE, clear all accumulators and the beat counter next cycle; minimum period BEATS+1 cycles per vector.
REQ-027 SHALL ignore in_valid and in_data while in DONE; no beat is lost or pre-accumulated.

Reset
REQ-028 SHALL, while rst is high at a clock edge, enter IDLE, clear accumulators and beat counter, and drive out_valid=0, out_data=0, out_sign=0, out_sat=0, in_ready=0.
REQ-029 SHALL drive in_ready=1 in the first cycle after rst deasserts; rst mid-vector discards all partial sums.

Verification (IN_DIM=4, LANES=2, OUT_DIM=2, BIT_CNT=8)
REQ-030 SHALL cover reset: hold rst 3 cycles -> all outputs 0, in_ready 0; one cycle after release in_ready=1.
REQ-031 SHALL cover basic vector: beat1 data {3,-5} w0=(1,1) w1=(0,0); beat2 {7,2} w0=(1,0) w1=(0,0) -> one cycle later out_valid=1, neuron0=3, neuron1=-7, out_sign=(1,0), out_sat=(0,0).
REQ-032 SHALL cover saturation: four inputs of 100, neuron0 weights all 1, neuron1 all 0 -> neuron0=127 sat=1 sign=1; neuron1=-128 sat=1 sign=0.
REQ-033 SHALL cover negation edge: four inputs of -128, all weights 0 -> acc=+512, out 127, sat=1, sign=1.
REQ-034 SHALL cover backpressure: out_ready low 5 cycles with in_valid pulsing -> out_valid and outputs unchanged, in_ready=0, next vector result independent of ignored beats.
REQ-035 SHALL cover reset mid-operation: rst after one accepted beat, then basic vector -> results identical to REQ-031.

Source files
------------

// File: rtl/bin_weight_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bin_weight_mac_seq : sequential binary-weight MAC, saturated output vector |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bin_weight_mac_seq #(
  parameter int IN_DIM  = 8,
  parameter int OUT_DIM = 4,
  parameter int BIT_CNT = 8,
  parameter int LANES   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*BIT_CNT-1:0]   in_data,
  input  logic [OUT_DIM*LANES-1:0]   in_weight,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_DIM*BIT_CNT-1:0] out_data,
  output logic [OUT_DIM-1:0]         out_sign,
  output logic [OUT_DIM-1:0]         out_sat
);

  localparam int BEATS   = IN_DIM / LANES;
  localparam int ACC_BIT = BIT_CNT + $clog2(IN_DIM) + 1;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [ACC_BIT-1:0] SAT_MAX =
    {{(ACC_BIT-BIT_CNT+1){1'b0}}, {(BIT_CNT-1){1'b1}}};
  localparam logic signed [ACC_BIT-1:0] SAT_MIN =
    {{(ACC_BIT-BIT_CNT+1){1'b1}}, {(BIT_CNT-1){1'b0}}};
  localparam logic [BIT_CNT-1:0] OUT_MAX = {1'b0, {(BIT_CNT-1){1'b1}}};
  localparam logic [BIT_CNT-1:0] OUT_MIN = {1'b1, {(BIT_CNT-1){1'b0}}};

  generate
    if (IN_DIM % LANES != 0) begin : g_bad_lanes
      $error("bin_weight_mac_seq: IN_DIM must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ready_q, ready_d;
  logic signed [ACC_BIT-1:0]  acc_q [OUT_DIM];
  logic signed [ACC_BIT-1:0]  acc_d [OUT_DIM];
  logic [OUT_DIM*BIT_CNT-1:0] data_q, data_d;
  logic [OUT_DIM-1:0]         sign_q, sign_d;
  logic [OUT_DIM-1:0]         sat_q, sat_d;
  logic                       w_fire;
  logic                       w_last;
  logic [BIT_CNT-1:0]         w_lane;
  logic signed [ACC_BIT-1:0]  w_ext;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    sign_d  = sign_q;
    sat_d   = sat_q;
    w_last  = 1'b0;
    w_lane  = '0;
    w_ext   = '0;
    // ready is registered, so a beat can only fire outside DONE
    w_fire  = in_valid && ready_q;

    case (state_q)
      IDLE, ACC: begin
        if (w_fire) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
            cnt_d   = '0;
            w_last  = 1'b1;
          end else begin
            state_d = ACC;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          for (int o = 0; o < OUT_DIM; o++) acc_d[o] = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_fire) begin
      for (int o = 0; o < OUT_DIM; o++) begin
        for (int k = 0; k < LANES; k++) begin
          w_lane = in_data[k*BIT_CNT +: BIT_CNT];
          w_ext  = {{(ACC_BIT-BIT_CNT){w_lane[BIT_CNT-1]}}, w_lane};
          if (in_weight[o*LANES+k]) acc_d[o] = acc_d[o] + w_ext;
          else                      acc_d[o] = acc_d[o] - w_ext;
        end
      end
    end

    // Output registers capture the final sums in the same edge that enters DONE
    if (w_last) begin
      for (int o = 0; o < OUT_DIM; o++) begin
        sign_d[o] = ~acc_d[o][ACC_BIT-1];
        if (acc_d[o] > SAT_MAX) begin
          data_d[o*BIT_CNT +: BIT_CNT] = OUT_MAX;
          sat_d[o]                     = 1'b1;
        end else if (acc_d[o] < SAT_MIN) begin
          data_d[o*BIT_CNT +: BIT_CNT] = OUT_MIN;
          sat_d[o]                     = 1'b1;
        end else begin
          data_d[o*BIT_CNT +: BIT_CNT] = acc_d[o][BIT_CNT-1:0];
          sat_d[o]                     = 1'b0;
        end
      end
    end

    ready_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      for (int o = 0; o < OUT_DIM; o++) acc_q[o] <= '0;
      data_q  <= '0;
      sign_q  <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      sign_q  <= sign_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_sign  = sign_q;
  assign out_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_weight_mac_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bin_weight_mac_seq : randomized self-checking bench with reference model|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bin_weight_mac_seq;

  localparam int IN_DIM  = 4;
  localparam int OUT_DIM = 2;
  localparam int BIT_CNT = 8;
  localparam int LANES   = 2;
  localparam int BEATS   = IN_DIM / LANES;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       in_valid = 1'b0;
  logic                       in_ready;
  logic [LANES*BIT_CNT-1:0]   in_data = '0;
  logic [OUT_DIM*LANES-1:0]   in_weight = '0;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [OUT_DIM*BIT_CNT-1:0] out_data;
  logic [OUT_DIM-1:0]         out_sign;
  logic [OUT_DIM-1:0]         out_sat;

  int total = 0;
  int bad   = 0;

  // Current vector: element values and per-neuron weights (1 => +1, 0 => -1)
  int vd [IN_DIM];
  bit vw [OUT_DIM][IN_DIM];

  bin_weight_mac_seq #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .BIT_CNT(BIT_CNT), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sign(out_sign), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_acc(input int o);
    int s = 0;
    for (int i = 0; i < IN_DIM; i++) s += vw[o][i] ? vd[i] : -vd[i];
    return s;
  endfunction

  function automatic int clampv(input int a);
    if (a > 127)  return 127;
    if (a < -128) return -128;
    return a;
  endfunction

  function automatic int neuron_out(input int o);
    return int'($signed(out_data[o*BIT_CNT +: BIT_CNT]));
  endfunction

  // Present one beat at a negedge once in_ready is seen; returns at the following negedge.
  task automatic send_beat(input int b, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 0, 1);
    for (int k = 0; k < LANES; k++) begin
      in_data[k*BIT_CNT +: BIT_CNT] = vd[b*LANES+k][BIT_CNT-1:0];
      for (int o = 0; o < OUT_DIM; o++) in_weight[o*LANES+k] = vw[o][b*LANES+k];
    end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input string tag, input int hold, input bit gaps);
    int acc;
    logic [OUT_DIM*BIT_CNT-1:0] snap_d;
    logic [OUT_DIM-1:0] snap_s, snap_t;
    for (int b = 0; b < BEATS; b++) begin
      send_beat(b, gaps ? int'($urandom_range(0, 2)) : 0);
      if (b < BEATS - 1) check({tag, "_early_valid"}, int'(out_valid), 0);
    end
    check({tag, "_valid"}, int'(out_valid), 1);
    for (int o = 0; o < OUT_DIM; o++) begin
      acc = model_acc(o);
      check($sformatf("%s_data%0d", tag, o), neuron_out(o), clampv(acc));
      check($sformatf("%s_sign%0d", tag, o), int'(out_sign[o]), (acc >= 0) ? 1 : 0);
      check($sformatf("%s_sat%0d", tag, o), int'(out_sat[o]),
            (acc > 127 || acc < -128) ? 1 : 0);
    end
    snap_d = out_data; snap_s = out_sign; snap_t = out_sat;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'($urandom);
      in_data  = LANES*BIT_CNT'($urandom);
      in_weight = OUT_DIM*LANES'($urandom);
      @(negedge clk);
      check({tag, "_hold_valid"}, int'(out_valid), 1);
      check({tag, "_hold_ready"}, int'(in_ready), 0);
      check({tag, "_hold_data"}, int'(out_data == snap_d && out_sign == snap_s
                                      && out_sat == snap_t), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, int'(out_valid), 0);
    check({tag, "_drain_ready"}, int'(in_ready), 1);
  endtask

  task automatic load_basic();
    vd = '{3, -5, 7, 2};
    for (int i = 0; i < IN_DIM; i++) vw[1][i] = 1'b0;
    vw[0][0] = 1'b1; vw[0][1] = 1'b1; vw[0][2] = 1'b1; vw[0][3] = 1'b0;
  endtask

  initial begin
    // Reset held for three edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_sign", int'(out_sign), 0);
    check("rst_sat", int'(out_sat), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", int'(in_ready), 1);

    load_basic();
    run_vector("basic", 0, 1'b0);
    check("basic_n0_const", neuron_out(0), 3);

    for (int i = 0; i < IN_DIM; i++) begin
      vd[i] = 100; vw[0][i] = 1'b1; vw[1][i] = 1'b0;
    end
    run_vector("satur", 0, 1'b0);

    for (int i = 0; i < IN_DIM; i++) begin
      vd[i] = -128; vw[0][i] = 1'b0; vw[1][i] = 1'b0;
    end
    run_vector("negedge", 5, 1'b0);

    // Mid-vector reset discards the partial sum
    load_basic();
    send_beat(0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", int'(in_ready), 0);
    check("midrst_valid", int'(out_valid), 0);
    load_basic();
    run_vector("midrst", 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < IN_DIM; i++) begin
        vd[i] = int'($urandom_range(0, 255)) - 128;
        for (int o = 0; o < OUT_DIM; o++) vw[o][i] = 1'($urandom);
      end
      run_vector("rand", int'($urandom_range(0, 4)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
